iob_eth_tx_sched: RTL and testbench
===================================

// Module: iob_eth_tx_sched
// PURPOSE
//  Transmit-frame scheduler in the system (clk) domain of the Ethernet core.
//  - Round-robin arbitration among N_REQ requesters (e.g. CPU driver, DMA) for the single TX path.
//  - Sequences the core's TX control for the winning requester:
//    1. program TX_NBYTES
//    2. pulse SEND
//    3. track the synchronized tx_ready status through the frame
//    4. report done, or error on timeout.
// PARAMETERS
//  N_REQ      2       number of requesters (1..8)
//  NBYTES_W   11      frame length width, bytes; matches TX buffer depth
//  TIMEOUT_W  16      width of the watchdog counter
//  TIMEOUT    16'hFFFF clk cycles allowed in each wait state before error
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 asynchronous reset, active high
//  req_valid    in   N_REQ             requester i has a frame ready in TX buffer
//  req_nbytes   in   N_REQ*NBYTES_W    frame length of requester i, slice [i*NBYTES_W +: NBYTES_W]
//  req_ready    out  N_REQ             accept strobe; handshake = req_valid[i] & req_ready[i]
//  done         out  N_REQ             1-cycle pulse: frame of requester i fully sent
//  err          out  N_REQ             1-cycle pulse: requester i rejected (nbytes==0) or timed out
//  tx_ready_i   in   1                 core TX ready status, already synchronized to clk
//  tx_nbytes_o  out  NBYTES_W          to core TX_NBYTES register
//  send_o       out  1                 to core SEND register, 1-cycle pulse
//  grant_o      out  N_REQ             one-hot owner of TX path, 0 when idle
//  busy_o       out  1                 state != IDLE
// BEHAVIOUR
//  Reset values
//  - All outputs 0.
//  - State IDLE; rr pointer = 0 (requester 0 highest priority); watchdog = 0.
//  States
//  - IDLE:
//    - When tx_ready_i=1 and any req_valid: pick the first valid index searching from rr pointer upward, wrapping.
//    - req_ready[win]=1 combinationally, this cycle only.
//    - Latch nbytes and grant; go to SEND.
//    - If latched nbytes==0: instead pulse err[win] next cycle, stay IDLE, advance rr pointer.
//    - When tx_ready_i=0: no req_ready is asserted.
//  - SEND:
//    - send_o=1 for exactly this cycle; go to WAIT_LO.
//    - tx_nbytes_o is valid from SEND entry and held until return to IDLE.
//  - WAIT_LO: wait for tx_ready_i=0 (core started frame; covers CDC latency of send); go to WAIT_HI.
//  - WAIT_HI: wait for tx_ready_i=1; go to DONE.
//  - DONE:
//    - done[grant]=1 for one cycle.
//    - rr pointer := grant index+1 mod N_REQ.
//    - grant_o cleared; go to IDLE.
//  Latency
//  - Handshake at cycle t gives send_o at t+1 and WAIT_LO at t+2.
//  - Min accept-to-done = 4 cycles + core time.
//  Watchdog
//  - Cleared on entry to WAIT_LO and to WAIT_HI; increments each cycle in those states.
//  - At count==TIMEOUT-1 while still waiting: err[grant] pulses next cycle, rr pointer advances, return to IDLE.
//    No done pulse in that case.
//  Boundaries
//  - req_valid may drop before acceptance: no effect, not latched.
//  - req_valid/req_nbytes of the granted requester are ignored after the handshake.
//  - Simultaneous requests are served strictly round robin; a lone requester may be granted back to back.
//  - tx_ready_i glitch high->low->high inside WAIT_HI: first high completes.
//  - At most one done/err bit high at any cycle, never both.
//  - rst asserted mid-frame: immediate IDLE, outputs 0, no done/err; core reset is handled separately.
// TESTING
//  1. Single request: tx_ready_i=1, req0 nbytes=64 -> req_ready[0] same cycle; send_o 1 cycle later;
//     tx_nbytes_o=64; model drops ready 3 cycles, raises 100 -> done[0] one cycle after rise.
//  2. req0 and req1 valid together, 4 frames -> grants 0,1,0,1; grant_o one-hot; busy_o high throughout.
//  3. tx_ready_i held 0 in IDLE with req1 valid -> no req_ready, no send_o, for 50 cycles.
//  4. TIMEOUT=32; core never drops ready -> err[grant] at 32 cycles after WAIT_LO entry; no done; IDLE.
//  5. req0 nbytes=0 -> req_ready[0], err[0] next cycle, send_o never asserted.
//  6. rst pulse in WAIT_HI -> all outputs 0 asynchronously; next request is served from requester 0.

Source files
------------

// File: rtl/iob_eth_tx_sched.sv
// Round-robin TX frame scheduler: picks a requester, programs TX_NBYTES, pulses SEND, tracks tx_ready to done/err.
// Accept-to-send 1 cycle, accept-to-done >= 4 cycles; requesters are only accepted in IDLE while tx_ready_i is high.
module iob_eth_tx_sched #(
    parameter int                   N_REQ     = 2,
    parameter int                   NBYTES_W  = 11,
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = {TIMEOUT_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*NBYTES_W-1:0] req_nbytes,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    input  logic                      tx_ready_i,
    output logic [NBYTES_W-1:0]       tx_nbytes_o,
    output logic                      send_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      busy_o
);

    localparam int                   IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [NBYTES_W-1:0]    nbytes_q, nbytes_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [TIMEOUT_W-1:0]   wd_q, wd_d;
    logic [N_REQ-1:0]       err_q, err_d;

    logic [IDX_W-1:0]       win;
    logic                   win_found;
    logic [NBYTES_W-1:0]    win_nbytes;
    logic                   accept;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= N_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // First valid requester at or above the rr pointer, wrapping around.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int               j;
            logic [IDX_W-1:0] cand;
            j = int'(rr_q) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = IDX_W'(j);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
        win_nbytes = req_nbytes[int'(win)*NBYTES_W +: NBYTES_W];
    end

    assign accept = (state_q == S_IDLE) && tx_ready_i && win_found;

    always_comb begin
        req_ready = '0;
        if (accept && !rst) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        nbytes_d = nbytes_q;
        grant_d  = grant_q;
        wd_d     = wd_q;
        err_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Zero-length frames are rejected without touching the core.
                    if (win_nbytes == '0) begin
                        err_d[win] = 1'b1;
                        rr_d       = next_idx(win);
                    end else begin
                        nbytes_d     = win_nbytes;
                        gidx_d       = win;
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                        state_d      = S_SEND;
                    end
                end
            end
            S_SEND: begin
                wd_d    = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!tx_ready_i) begin
                    wd_d    = '0;
                    state_d = S_WAIT_HI;
                end else if (wd_q == WD_LAST) begin
                    err_d[gidx_q] = 1'b1;
                    rr_d          = next_idx(gidx_q);
                    grant_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (tx_ready_i) begin
                    state_d = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    err_d[gidx_q] = 1'b1;
                    rr_d          = next_idx(gidx_q);
                    grant_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                rr_d    = next_idx(gidx_q);
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            gidx_q   <= '0;
            nbytes_q <= '0;
            grant_q  <= '0;
            wd_q     <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gidx_q   <= gidx_d;
            nbytes_q <= nbytes_d;
            grant_q  <= grant_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        done = '0;
        if (state_q == S_DONE) begin
            done[gidx_q] = 1'b1;
        end
    end

    assign err         = err_q;
    assign send_o      = (state_q == S_SEND);
    assign busy_o      = (state_q != S_IDLE);
    assign grant_o     = grant_q;
    assign tx_nbytes_o = nbytes_q;

endmodule

// File: tb/tb_iob_eth_tx_sched.sv
// Directed bench for iob_eth_tx_sched: vector table for single-frame and zero-length cases, plus
// hand-written sequences for reset mid-frame, round robin, tx_ready held low and watchdog timeout.
module tb_iob_eth_tx_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [10:0] nb0, nb1;
    logic [21:0] req_nbytes;
    logic [1:0]  req_ready, done, err, grant_o;
    logic        tx_ready_i, send_o, busy_o;
    logic [10:0] tx_nbytes_o;

    int total = 0;
    int bad   = 0;

    assign req_nbytes = {nb1, nb0};

    iob_eth_tx_sched #(
        .N_REQ    (2),
        .NBYTES_W (11),
        .TIMEOUT_W(16),
        .TIMEOUT  (16'd32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_nbytes (req_nbytes),
        .req_ready  (req_ready),
        .done       (done),
        .err        (err),
        .tx_ready_i (tx_ready_i),
        .tx_nbytes_o(tx_nbytes_o),
        .send_o     (send_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".req_ready"}, {30'd0, req_ready}, 32'd0);
        chk({nm, ".send"},      {31'd0, send_o},    32'd0);
        chk({nm, ".done"},      {30'd0, done},      32'd0);
        chk({nm, ".err"},       {30'd0, err},       32'd0);
        chk({nm, ".grant"},     {30'd0, grant_o},   32'd0);
        chk({nm, ".busy"},      {31'd0, busy_o},    32'd0);
        chk({nm, ".nbytes"},    {21'd0, tx_nbytes_o}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  rv;
        logic [10:0] nb0;
        logic        tx;
        logic [1:0]  e_rdy;
        logic        e_send;
        logic [1:0]  e_done;
        logic [1:0]  e_err;
        logic [1:0]  e_grant;
        logic        e_busy;
        logic        chk_nb;
        logic [10:0] e_nb;
    } vec_t;

    vec_t tab[13];

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [1:0] exp_g;
        int         n;

        //          rv     nb0     tx    rdy    send  done   err    grant  busy  chk   nb
        tab[0]  = '{2'b01, 11'd64, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 11'd0};
        tab[1]  = '{2'b00, 11'd64, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 11'd64};
        tab[2]  = '{2'b00, 11'd64, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 11'd64};
        tab[3]  = '{2'b00, 11'd64, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 11'd64};
        tab[4]  = '{2'b00, 11'd64, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 11'd64};
        tab[5]  = '{2'b00, 11'd64, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 11'd64};
        tab[6]  = '{2'b00, 11'd64, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 11'd64};
        tab[7]  = '{2'b00, 11'd64, 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1, 11'd64};
        tab[8]  = '{2'b00, 11'd64, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 11'd0};
        // Zero-length request from requester 0 (rr pointer now 1, wraps to 0).
        tab[9]  = '{2'b01, 11'd0,  1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 11'd0};
        tab[10] = '{2'b00, 11'd0,  1'b1, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 11'd0};
        tab[11] = '{2'b00, 11'd0,  1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 11'd0};
        tab[12] = '{2'b00, 11'd0,  1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 11'd0};

        // Reset: outputs must be 0 even with requests pending and core ready.
        rst = 1'b1; req_valid = 2'b11; nb0 = 11'd5; nb1 = 11'd6; tx_ready_i = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single frame and zero-length rejection.
        for (int v = 0; v < 13; v++) begin
            req_valid  = tab[v].rv;
            nb0        = tab[v].nb0;
            tx_ready_i = tab[v].tx;
            @(negedge clk);
            chk($sformatf("vec%0d.req_ready", v), {30'd0, req_ready}, {30'd0, tab[v].e_rdy});
            chk($sformatf("vec%0d.send", v),      {31'd0, send_o},    {31'd0, tab[v].e_send});
            chk($sformatf("vec%0d.done", v),      {30'd0, done},      {30'd0, tab[v].e_done});
            chk($sformatf("vec%0d.err", v),       {30'd0, err},       {30'd0, tab[v].e_err});
            chk($sformatf("vec%0d.grant", v),     {30'd0, grant_o},   {30'd0, tab[v].e_grant});
            chk($sformatf("vec%0d.busy", v),      {31'd0, busy_o},    {31'd0, tab[v].e_busy});
            if (tab[v].chk_nb)
                chk($sformatf("vec%0d.nbytes", v), {21'd0, tx_nbytes_o}, {21'd0, tab[v].e_nb});
            @(posedge clk); #1;
        end

        // Reset in WAIT_HI; rr pointer is 1 here so requester 1 wins first.
        req_valid = 2'b11; nb0 = 11'd300; nb1 = 11'd400; tx_ready_i = 1'b1;
        @(negedge clk);
        chk("rst6.req_ready", {30'd0, req_ready}, 32'd2);
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk);
        chk("rst6.grant", {30'd0, grant_o}, 32'd2);
        chk("rst6.nbytes", {21'd0, tx_nbytes_o}, 32'd400);
        @(posedge clk); #1; tx_ready_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst6.busy_wait_hi", {31'd0, busy_o}, 32'd1);
        #2 rst = 1'b1; req_valid = 2'b11; tx_ready_i = 1'b1;
        #1 chk_all_zero("rst6.async");
        @(posedge clk); #1;
        chk_all_zero("rst6.held");
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Round robin between two simultaneous requesters, starting from 0 after reset.
        req_valid = 2'b11; nb0 = 11'd100; nb1 = 11'd200; tx_ready_i = 1'b1;
        for (int f = 0; f < 4; f++) begin
            exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            @(negedge clk);
            while (req_ready == 2'b00 && n < 20) begin
                @(posedge clk); #1; @(negedge clk); n++;
            end
            chk($sformatf("rr%0d.req_ready", f), {30'd0, req_ready}, {30'd0, exp_g});
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rr%0d.send", f),   {31'd0, send_o},  32'd1);
            chk($sformatf("rr%0d.grant", f),  {30'd0, grant_o}, {30'd0, exp_g});
            chk($sformatf("rr%0d.busy_s", f), {31'd0, busy_o},  32'd1);
            chk($sformatf("rr%0d.nbytes", f), {21'd0, tx_nbytes_o}, (f % 2 == 0) ? 32'd100 : 32'd200);
            @(posedge clk); #1; tx_ready_i = 1'b0;
            @(negedge clk);
            chk($sformatf("rr%0d.busy_lo", f), {31'd0, busy_o}, 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rr%0d.busy_hi", f), {31'd0, busy_o}, 32'd1);
            @(posedge clk); #1; tx_ready_i = 1'b1;
            n = 0;
            @(negedge clk);
            while (done == 2'b00 && n < 20) begin
                @(posedge clk); #1; @(negedge clk); n++;
            end
            chk($sformatf("rr%0d.done", f),   {30'd0, done},  {30'd0, exp_g});
            chk($sformatf("rr%0d.err", f),    {30'd0, err},   32'd0);
            chk($sformatf("rr%0d.busy_d", f), {31'd0, busy_o}, 32'd1);
            @(posedge clk); #1;
        end

        // tx_ready low in IDLE: no acceptance however long the request waits.
        req_valid = 2'b10; nb1 = 11'd500; tx_ready_i = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d.req_ready", c), {30'd0, req_ready}, 32'd0);
            chk($sformatf("hold%0d.send", c),      {31'd0, send_o},    32'd0);
            @(posedge clk); #1;
        end

        // Watchdog: core never drops ready after SEND.
        tx_ready_i = 1'b1;
        @(negedge clk);
        chk("wd.req_ready", {30'd0, req_ready}, 32'd2);
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk);
        chk("wd.send", {31'd0, send_o}, 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            chk($sformatf("wd%0d.done", k), {30'd0, done}, 32'd0);
            if (k < 32) begin
                chk($sformatf("wd%0d.err", k),  {30'd0, err},    32'd0);
                chk($sformatf("wd%0d.busy", k), {31'd0, busy_o}, 32'd1);
            end else begin
                chk("wd_end.err",   {30'd0, err},     32'd2);
                chk("wd_end.busy",  {31'd0, busy_o},  32'd0);
                chk("wd_end.grant", {30'd0, grant_o}, 32'd0);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("wd_after.err", {30'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
